// File: rtl/led_pkg.sv
// Shared constants and types for the eight-channel LED fader.
package led_pkg;

  localparam int LED_N     = 8;
  localparam int PWM_W_DEF = 8;

  typedef logic [PWM_W_DEF-1:0] led_level_t;
  typedef logic [LED_N-1:0]     led_vec_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int unsigned cnt_width(input int unsigned range_n);
    return (range_n <= 1) ? 1 : $clog2(range_n);
  endfunction

endpackage

// File: rtl/led_fade_ch.sv
// One LED channel: brightness level that ramps toward its on/off target,
// plus the PWM comparator and registered pad drive.
module led_fade_ch #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             fade_en_i,
  input  logic             on_i,
  input  logic [PWM_W-1:0] pcnt_i,
  output logic             pend_o,
  output logic             led_o
);

  localparam logic [PWM_W-1:0] LMAX = '1;
  localparam logic [PWM_W-1:0] ONE  = PWM_W'(1);

  logic [PWM_W-1:0] level_q, level_d;
  logic [PWM_W-1:0] target;
  logic             led_q;

  assign target = on_i ? LMAX : '0;

  always_comb begin
    level_d = level_q;
    if (!fade_en_i) begin
      level_d = target;
    end else if (tick_i) begin
      if (level_q < target) begin
        level_d = level_q + ONE;
      end else if (level_q > target) begin
        level_d = level_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= (level_q > pcnt_i);
    end
  end

  // Pending is judged on the next-state level so busy lines up with the level register.
  assign pend_o = (level_d != target);
  assign led_o  = led_q;

endmodule

// File: rtl/led_fade.sv
// LED fader top: free-running fade prescaler and PWM counter shared by
// LED_N channels, with a registered busy flag.
module led_fade
  import led_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int PWM_W    = PWM_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  led_vec_t led_i,
  input  logic     fade_en,
  output led_vec_t led_o,
  output logic     busy
);

  localparam int               PS_W      = cnt_width(PRESCALE);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ONE    = PS_W'(1);
  // PWM period is LMAX cycles, so pcnt tops out at LMAX-1.
  localparam logic [PWM_W-1:0] PCNT_LAST = PWM_W'((2 ** PWM_W) - 2);
  localparam logic [PWM_W-1:0] PCNT_ONE  = PWM_W'(1);

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [PWM_W-1:0] pcnt_q, pcnt_d;
  logic             busy_q, busy_d;
  logic             tick;
  led_vec_t         pend;

  always_comb begin
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + PS_ONE;
    pcnt_d  = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_ONE;
    busy_d  = |pend;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      busy_q  <= busy_d;
    end
  end

  generate
    for (genvar gi = 0; gi < LED_N; gi++) begin : g_ch
      led_fade_ch #(
        .PWM_W (PWM_W)
      ) u_ch (
        .clk       (clk),
        .rst_ni    (rst),
        .tick_i    (tick),
        .fade_en_i (fade_en),
        .on_i      (led_i[gi]),
        .pcnt_i    (pcnt_q),
        .pend_o    (pend[gi]),
        .led_o     (led_o[gi])
      );
    end
  endgenerate

  assign busy = busy_q;

endmodule

// File: tb/tb_led_fade.sv
// Self-checking bench for led_fade with PRESCALE=4, PWM_W=4 against a
// cycle-count based brightness model.
module tb_led_fade;

  localparam int P    = 4;
  localparam int W    = 4;
  localparam int LMAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic       fade_in = 1'b1;
  logic [7:0] led_o;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model: n counts clock edges since reset release; the fade tick is
  // every P-th edge and the PWM phase is n mod LMAX.
  int         n;
  int         lvl [8];
  logic [7:0] led_m;
  logic       busy_m;

  always #5 clk = ~clk;

  led_fade #(
    .PRESCALE (P),
    .PWM_W    (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led_i   (led_in),
    .fade_en (fade_in),
    .led_o   (led_o),
    .busy    (busy)
  );

  task automatic model_reset();
    n      = 0;
    led_m  = 8'h00;
    busy_m = 1'b0;
    for (int i = 0; i < 8; i++) lvl[i] = 0;
  endtask

  task automatic step();
    int  phase;
    bit  tck;
    int  tgt;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      phase = n % LMAX;
      tck   = ((n % P) == P - 1);
      for (int i = 0; i < 8; i++) led_m[i] = (lvl[i] > phase);
      busy_m = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tgt = led_in[i] ? LMAX : 0;
        if (!fade_in)             lvl[i] = tgt;
        else if (tck && lvl[i] < tgt) lvl[i] = lvl[i] + 1;
        else if (tck && lvl[i] > tgt) lvl[i] = lvl[i] - 1;
        if (lvl[i] != tgt) busy_m = 1'b1;
      end
      n++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; led_in = 8'hFF; fade_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (led_o !== 8'h00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d led_o=%h busy=%b required led_o=00 busy=0", c, led_o, busy);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_busy busy=%b required 1", busy);
    end
    for (int c = 0; c < 70; c++) begin
      step();
      checks++;
      if (led_o !== led_m || busy !== busy_m) begin
        errors++;
        $display("FAIL reset_ramp cyc %0d led_o=%h exp %h busy=%b exp %b", c, led_o, led_m, busy, busy_m);
      end
    end
  endtask

  task automatic test_rise();
    int  k;
    bit  done;
    fade_in = 1'b0; led_in = 8'h00;
    step(); step();
    fade_in = 1'b1; led_in = 8'h01;
    done = 1'b0;
    k = 0;
    while (!done && k < 70) begin
      step();
      k++;
      checks++;
      if (led_o !== led_m || busy !== busy_m) begin
        errors++;
        $display("FAIL rise cyc %0d led_o=%h exp %h busy=%b exp %b", k, led_o, led_m, busy, busy_m);
      end
      if (busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done || k > 60) begin
      errors++;
      $display("FAIL rise_time cycles=%0d required <=60 and busy low", k);
    end
    for (int c = 0; c < 30; c++) begin
      step();
      checks++;
      if (led_o[0] !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL full_on cyc %0d led_o[0]=%b busy=%b required 1 0", c, led_o[0], busy);
      end
    end
  endtask

  // Ramp channel 0 up to level 'at', then drop the request; the fall must
  // start from 'at' and take exactly 'at' ticks.
  task automatic test_reverse(input int at);
    int  k;
    bit  done;
    fade_in = 1'b0; led_in = 8'h00;
    step(); step();
    fade_in = 1'b1; led_in = 8'h01;
    k = 0;
    while (lvl[0] != at && k < 60) begin
      step();
      k++;
      checks++;
      if (led_o !== led_m || busy !== busy_m) begin
        errors++;
        $display("FAIL rev%0d_up cyc %0d led_o=%h exp %h busy=%b exp %b", at, k, led_o, led_m, busy, busy_m);
      end
    end
    led_in = 8'h00;
    done = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      step();
      k++;
      checks++;
      if (led_o !== led_m || busy !== busy_m) begin
        errors++;
        $display("FAIL rev%0d_down cyc %0d led_o=%h exp %h busy=%b exp %b", at, k, led_o, led_m, busy, busy_m);
      end
      if (busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done || k != at * P) begin
      errors++;
      $display("FAIL rev%0d_fall_time cycles=%0d required %0d", at, k, at * P);
    end
  endtask

  task automatic test_direct();
    fade_in = 1'b0; led_in = 8'hA5;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || (c >= 2 && led_o !== 8'hA5) || led_o !== led_m) begin
        errors++;
        $display("FAIL direct cyc %0d led_o=%h exp %h busy=%b required 0", c, led_o, led_m, busy);
      end
    end
    led_in = 8'h5A;
    step(); step();
    checks++;
    if (led_o !== 8'h5A || busy !== 1'b0) begin
      errors++;
      $display("FAIL direct_change led_o=%h busy=%b required 5a 0", led_o, busy);
    end
  endtask

  task automatic test_async_reset();
    fade_in = 1'b1; led_in = 8'hFF;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (led_o !== led_m || busy !== busy_m) begin
        errors++;
        $display("FAIL pre_areset cyc %0d led_o=%h exp %h busy=%b exp %b", c, led_o, led_m, busy, busy_m);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (led_o !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate led_o=%h busy=%b required 00 0", led_o, busy);
    end
    #2 rst = 1'b1;
    model_reset();
    step();
    checks++;
    if (led_o !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_restart led_o=%h busy=%b required 00 1", led_o, busy);
    end
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (led_o !== led_m || busy !== busy_m) begin
        errors++;
        $display("FAIL post_areset cyc %0d led_o=%h exp %h busy=%b exp %b", c, led_o, led_m, busy, busy_m);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) led_in = 8'($urandom);
      if ($urandom_range(0, 31) == 0) fade_in = ~fade_in;
      step();
      checks++;
      if (led_o !== led_m || busy !== busy_m) begin
        errors++;
        $display("FAIL random cyc %0d led_i=%h fade=%b led_o=%h exp %h busy=%b exp %b",
                 c, led_in, fade_in, led_o, led_m, busy, busy_m);
      end
    end
    fade_in = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rise();
    test_reverse(5);
    test_reverse(7);
    test_direct();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_fade.md
LED_FADE -- requirements
Module: led_fade

Interface
REQ-001 Parameter PRESCALE, default 1000, clk cycles per fade step (>=1).
REQ-002 Parameter PWM_W, default 8, brightness level width; LMAX = 2**PWM_W-1.
REQ-003 clk  input  1  system clock; sole clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 led_i  input  8  target pattern from the LED register peripheral (1 = on).
REQ-006 fade_en  input  1  1 = fade mode; 0 = direct mode, no ramping.
REQ-007 led_o  output  8  PWM-modulated pad drive, active-high, registered.
REQ-008 busy  output  1  registered; high while any channel level differs from its target.

Function
REQ-009 Prescaler counts 0..PRESCALE-1 and wraps; one-cycle tick asserted when count = PRESCALE-1.
REQ-010 PWM counter pcnt counts 0..LMAX-1 and wraps, advancing every cycle; PWM period = LMAX cycles.
REQ-011 Each channel i holds level[i], PWM_W bits; target[i] = LMAX if led_i[i] else 0.
REQ-012 Fade mode, tick cycle: level[i] +1 if below target, -1 if above, unchanged if equal; no overflow or underflow.
REQ-013 Non-tick cycles: level[i] unchanged.
REQ-014 led_i change mid-ramp: ramp reverses from the current level at the next tick; no jump, no restart.
REQ-015 Direct mode: level[i] <= target[i] every cycle, regardless of tick.
REQ-016 led_o[i] registered as (level[i] > pcnt); level = LMAX is constantly high, level 0 constantly low.
REQ-017 Latency: level update to led_o is 1 cycle; led_i change to first level step is at most PRESCALE cycles.
REQ-018 busy <= OR over i of (level[i] != target[i]), evaluated on the next-state levels.
REQ-019 fade_en 1->0 mid-ramp: levels snap to target next cycle and busy clears the same cycle.
REQ-020 Prescaler and pcnt run freely in both modes and are never restarted by led_i or fade_en changes.

Reset
REQ-021 While rst is low: all levels, prescaler, pcnt, led_o and busy are 0, immediately and asynchronously.
REQ-022 After rst deasserts, operation resumes from zero levels.
REQ-023 A nonzero led_i at reset release (LED register reset pattern 0x0F) fades channels 0-3 up, with busy high from the first cycle.
REQ-024 Reset mid-ramp discards all ramp state.

Structure
REQ-025 Shared package led_pkg holds: constant LED_N = 8, default PWM_W, typedef led_level_t (PWM_W-bit level), typedef led_vec_t (LED_N-bit vector).
REQ-026 Sub-module led_fade_ch, instantiated LED_N times, holds one level register, its step logic and its PWM comparator/output flop.
REQ-027 Top level holds the prescaler, pcnt and busy reduction.

Verification (PRESCALE=4, PWM_W=4, LMAX=15)
REQ-028 Hold rst low with led_i=0xFF -> led_o=0x00, busy=0; after release, level[7:0] ramp up and busy=1 next cycle.
REQ-029 fade_en=1, led_i 0x00->0x01 -> level[0] reaches 15 after 15 ticks (<=60 cycles), busy drops within 1 cycle of that, then led_o[0] constantly 1.
REQ-030 Ramp channel 0 to level 5, then led_i=0x00 -> led_o[0] high exactly 5 of every 15 cycles before the change, then ramps to 0 in 5 ticks.
REQ-031 At level 7 rising, led_i 0x01->0x00 -> next tick level 6, no jump to 0 or 15.
REQ-032 fade_en=0, led_i=0xA5 -> led_o=0xA5 two cycles later (level, then output flop), busy=0 throughout.
REQ-033 Mid-ramp rst pulse of 1 cycle, asynchronous to clk -> led_o=0 immediately; after release, ramp restarts from level 0.
